// File: rtl/seq_div_hilo_pkg.sv
// Shared types and constants for the HI/LO sequential divider.
package seq_div_hilo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      ZERO = 2'b11
   } div_state_e;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DIV_LATENCY   = DEFAULT_WIDTH + 1;
   localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

   function automatic int unsigned div_latency(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/seq_div_hilo_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The shifted remainder keeps its carry bit so divisors above 2^(WIDTH-1) still compare correctly;
   // since rem_in < dvs, diff[WIDTH] is exactly the borrow.
   always_comb begin
      shifted = {rem_in, q_msb};
      diff    = shifted - {1'b0, dvs};
      q_bit   = ~diff[WIDTH];
      rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_div_hilo.sv
// Multi-cycle restoring divider writing quotient (LO) and remainder (HI) of the HI/LO pair.
module seq_div_hilo
   import seq_div_hilo_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             hi_wr,
   output logic             lo_wr,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sign_q_q, sign_q_d;
   logic             sign_r_q, sign_r_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_bit;
   logic             sa, sb;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .q_msb   (q_q[WIDTH-1]),
      .dvs     (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rem_d    = rem_q;
      q_d      = q_q;
      dvs_d    = dvs_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      sa       = div_signed & dividend[WIDTH-1];
      sb       = div_signed & divisor[WIDTH-1];

      case (state_q)
         IDLE: begin
            if (div_start) begin
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  // The quotient register parks the raw dividend until it lands in HI.
                  state_d = ZERO;
                  q_d     = dividend;
               end else begin
                  state_d  = RUN;
                  q_d      = sa ? -dividend : dividend;
                  dvs_d    = sb ? -divisor : divisor;
                  rem_d    = '0;
                  count_d  = '0;
                  sign_q_d = sa ^ sb;
                  sign_r_d = sa;
               end
            end
         end
         RUN: begin
            rem_d   = step_rem;
            q_d     = {q_q[WIDTH-2:0], step_bit};
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) begin
               state_d = FIX;
            end
         end
         FIX: begin
            lo_d    = sign_q_q ? -q_q : q_q;
            hi_d    = sign_r_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         ZERO: begin
            lo_d    = '1;
            hi_d    = q_q;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == FIX);
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         q_q      <= '0;
         dvs_q    <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         q_q      <= q_d;
         dvs_q    <= dvs_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi_wr       = done_q;
   assign lo_wr       = done_q;
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_hilo.sv
// Directed bench for seq_div_hilo with a cycle-level arithmetic reference model.
module tb_seq_div_hilo;

   logic        Clock;
   logic        Clear;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        hi_wr;
   logic        lo_wr;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int          m_left = 0;
   logic        m_zero = 1'b0;
   logic [31:0] p_lo = '0, p_hi = '0;
   logic        p_dz = 1'b0;
   logic [31:0] e_lo = '0, e_hi = '0;
   logic        e_dz = 1'b0, e_done = 1'b0, e_busy = 1'b0;

   seq_div_hilo #(.WIDTH(32)) dut (
      .Clock       (Clock),
      .Clear       (Clear),
      .div_start   (div_start),
      .div_signed  (div_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .hi_wr       (hi_wr),
      .lo_wr       (lo_wr),
      .hi_out      (hi_out),
      .lo_out      (lo_out),
      .div_by_zero (div_by_zero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] lo, output logic [31:0] hi, output logic dz);
      longint sa, sb;
      if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
         dz = 1'b1;
      end else if (!s) begin
         lo = a / b;
         hi = a % b;
         dz = 1'b0;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lo = 32'(sa / sb);
         hi = 32'(sa % sb);
         dz = 1'b0;
      end
   endfunction

   // Cycle-level reference: a countdown per accepted request, results published when it expires.
   initial begin
      forever begin
         @(posedge Clock or negedge Clear);
         if (!Clear) begin
            m_left = 0; m_zero = 1'b0;
            e_done = 1'b0; e_busy = 1'b0; e_lo = '0; e_hi = '0; e_dz = 1'b0;
         end else begin
            e_done = 1'b0;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  e_done = 1'b1; e_lo = p_lo; e_hi = p_hi; e_dz = p_dz;
               end
            end else if (div_start) begin
               model(dividend, divisor, div_signed, p_lo, p_hi, p_dz);
               m_zero = (divisor == 32'd0);
               m_left = m_zero ? 1 : 33;
               e_dz   = 1'b0;
            end
            e_busy = (m_left > 0) && !m_zero;
         end
      end
   end

   initial begin
      forever begin
         @(negedge Clock);
         check("busy",   32'(busy),        32'(e_busy));
         check("done",   32'(done),        32'(e_done));
         check("hi_wr",  32'(hi_wr),       32'(e_done));
         check("lo_wr",  32'(lo_wr),       32'(e_done));
         check("dbz",    32'(div_by_zero), 32'(e_dz));
         check("lo_out", lo_out,           e_lo);
         check("hi_out", hi_out,           e_hi);
      end
   end

   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(negedge Clock);
         lat++;
         if (busy) bcnt++;
      end
   endtask

   task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] xlo, input logic [31:0] xhi, input logic xdz,
                          input int xlat);
      int lat, bcnt;
      @(negedge Clock);
      div_start = 1'b1; dividend = a; divisor = b; div_signed = s;
      @(negedge Clock);
      div_start = 1'b0; dividend = $urandom; divisor = $urandom; div_signed = 1'($urandom);
      wait_done(lat, bcnt);
      check({nm, "_latency"}, 32'(lat), 32'(xlat));
      check({nm, "_busy_cycles"}, 32'(bcnt), (xlat == 1) ? 32'd0 : 32'(xlat));
      check({nm, "_lo"}, lo_out, xlo);
      check({nm, "_hi"}, hi_out, xhi);
      check({nm, "_dbz"}, 32'(div_by_zero), 32'(xdz));
      check({nm, "_wr"}, {30'd0, hi_wr, lo_wr}, 32'd3);
   endtask

   initial begin
      logic [31:0] mlo, mhi;
      logic        mdz;
      int          lat, bcnt, seen;

      Clear = 1'b0; div_start = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;

      // pin the reference model against hand-computed results
      model(32'd100, 32'd7, 1'b0, mlo, mhi, mdz);
      check("model_100_7", mlo ^ mhi, 32'd14 ^ 32'd2);
      model(32'hFFFF_FFF9, 32'd2, 1'b1, mlo, mhi, mdz);
      check("model_m7_2_lo", mlo, 32'hFFFF_FFFD);
      check("model_m7_2_hi", mhi, 32'hFFFF_FFFF);
      model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mlo, mhi, mdz);
      check("model_min_m1_lo", mlo, 32'h8000_0000);
      model(32'h1234_5678, 32'd0, 1'b1, mlo, mhi, mdz);
      check("model_div0", {mlo[31:1], mdz}, {31'h7FFF_FFFF, 1'b1});

      repeat (2) @(negedge Clock);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_lo", lo_out, 32'd0);
      check("reset_hi", hi_out, 32'd0);
      Clear = 1'b1;

      run_div("u_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33);
      run_div("s_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33);
      run_div("s_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 33);
      run_div("div0",       32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1);
      run_div("u_20_3",     32'd20,         32'd3,          1'b0, 32'd6,          32'd2,          1'b0, 33);
      run_div("s_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 33);
      run_div("u_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 33);
      run_div("u_max_big",  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 32'd1,          32'd1,          1'b0, 33);
      run_div("s_m100_m7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 33);

      // start during a run is ignored; start in the done cycle is accepted
      @(negedge Clock);
      div_start = 1'b1; dividend = 32'd1000; divisor = 32'd7; div_signed = 1'b0;
      @(negedge Clock);
      div_start = 1'b0;
      repeat (9) @(negedge Clock);
      div_start = 1'b1; dividend = 32'd50; divisor = 32'd3; div_signed = 1'b1;
      @(negedge Clock);
      div_start = 1'b0;
      wait_done(lat, bcnt);
      check("ignored_start_lat", 32'(lat + 10), 32'd33);
      check("ignored_start_lo", lo_out, 32'd142);
      check("ignored_start_hi", hi_out, 32'd6);
      div_start = 1'b1; dividend = 32'd45; divisor = 32'd6; div_signed = 1'b0;
      @(negedge Clock);
      div_start = 1'b0;
      wait_done(lat, bcnt);
      check("chained_lat", 32'(lat), 32'd33);
      check("chained_lo", lo_out, 32'd7);
      check("chained_hi", hi_out, 32'd3);

      // asynchronous clear in the middle of a run
      @(negedge Clock);
      div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3; div_signed = 1'b0;
      @(negedge Clock);
      div_start = 1'b0;
      repeat (13) @(negedge Clock);
      #2 Clear = 1'b0;
      #1;
      check("clear_busy", 32'(busy), 32'd0);
      check("clear_lo", lo_out, 32'd0);
      check("clear_hi", hi_out, 32'd0);
      check("clear_done", 32'(done), 32'd0);
      @(negedge Clock);
      Clear = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge Clock);
         if (done) seen++;
      end
      check("clear_no_done", 32'(seen), 32'd0);
      run_div("after_clear", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 33);

      repeat (3) @(negedge Clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_div_hilo.md
Name: seq_div_hilo

Overview:
- Multi-cycle restoring divider that produces the quotient and remainder for the HI/LO register pair of the datapath.
- Acts as the writer side of HI/LO. The control unit pulses div_start with the operands from the bus and Y. When done asserts, the block drives hi_wr/lo_wr with the results so a later mfhi/mflo reads them.
- Supports signed and unsigned division. Divide-by-zero is flagged.

Parameters:
WIDTH, 32, operand/result width; all arithmetic assumes WIDTH >= 2.

Ports:
Clock  in  1  system clock, rising edge.
Clear  in  1  asynchronous, active-low reset.
div_start  in  1  one-cycle request; operands are sampled on the same edge.
div_signed  in  1  1 = signed (div), 0 = unsigned (divu); sampled with div_start.
dividend  in  WIDTH  numerator (from Y).
divisor  in  WIDTH  denominator (from bus).
busy  out  1  high from the edge after accepted start until done.
done  out  1  one-cycle pulse; results are valid on hi_out/lo_out.
hi_wr  out  1  equals done; datapath HIin strobe.
lo_wr  out  1  equals done; datapath LOin strobe.
hi_out  out  WIDTH  remainder, held until the next completion.
lo_out  out  WIDTH  quotient, held until the next completion.
div_by_zero  out  1  set with done when divisor==0; held until the next accepted start.

Behaviour:
- Reset (Clear=0, asynchronous):
  - state=IDLE.
  - busy, done, hi_wr, lo_wr and div_by_zero = 0.
  - hi_out and lo_out = 0.
  - Iteration counter = 0.
  - Reset mid-operation aborts silently; no done is produced.
- States: IDLE, RUN, FIX, ZERO. Let edge k be the one that accepts div_start.
- IDLE, div_start=1, divisor!=0 → RUN:
  - Capture |dividend| and |divisor| (magnitudes only if div_signed; otherwise raw).
  - Capture sign_q = sa^sb and sign_r = sa.
  - Clear partial remainder; count=0.
- IDLE, div_start=1, divisor==0 → ZERO:
  - At edge k+1, lo_out=all-ones and hi_out=dividend (raw).
  - div_by_zero=1 and done=1 for one cycle, then IDLE. Latency is 1.
- RUN, one restoring step per edge:
  - rem = {rem[WIDTH-2:0], q[WIDTH-1]}; q <<= 1.
  - If rem >= dvs: rem -= dvs and q[0]=1.
  - After WIDTH steps (edge k+WIDTH), go to FIX.
- FIX, edge k+WIDTH+1:
  - lo_out = sign_q ? -q : q.
  - hi_out = sign_r ? -rem : rem.
  - done=1 for one cycle; next state IDLE.
  - Total latency is WIDTH+1 edges (33 for WIDTH=32).
- busy is 1 in RUN and FIX, and 0 in IDLE and ZERO.
- div_start while not IDLE is ignored: no queueing, operands unchanged.
- div_start on the same edge that done falls is accepted, since state is IDLE in that cycle.
- Magnitudes are taken in WIDTH-bit unsigned arithmetic, so |-2^(WIDTH-1)| = 2^(WIDTH-1).
  - Signed 0x80000000 / -1 therefore yields lo=0x80000000 and hi=0, with no trap.
- Remainder sign follows the dividend; quotient truncates toward zero.
- done, hi_wr and lo_wr are asserted only in the single completion cycle. Outputs are registered, with no combinational path from inputs.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=2'b00, RUN=2'b01, FIX=2'b10, ZERO=2'b11).
  - DIV_LATENCY = WIDTH+1.
  - DIV0_QUOTIENT = all-ones.
- One sub-module, div_step: combinational single restoring iteration, (rem_in, q_msb, dvs) → (rem_out, q_bit).
  - Instantiated once; the FSM/counter lives in seq_div_hilo.

Test Plan:
- Unsigned 100/7, div_signed=0 → done exactly 33 cycles after the start edge; lo_out=14, hi_out=2; hi_wr=lo_wr=1 for one cycle; busy high for 33 cycles.
- Signed -7/2 → lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Also signed 7/-2 → lo_out=0xFFFFFFFD, hi_out=1.
- Divisor 0, dividend 0x12345678 → done one cycle after start; lo_out=0xFFFFFFFF, hi_out=0x12345678, div_by_zero=1. Next valid start clears div_by_zero.
- Signed 0x80000000 / 0xFFFFFFFF → lo_out=0x80000000, hi_out=0. Also unsigned 0xFFFFFFFF/1 → lo_out=0xFFFFFFFF, hi_out=0.
- Second div_start 10 cycles into a run, with different operands → ignored; first results are correct. A start in the cycle after done is accepted and completes normally.
- Clear pulsed low at cycle 15 of a run → busy=0 and hi_out/lo_out=0 immediately; no done pulse. A new start afterward completes correctly.
